mw_adder_seq: RTL and testbench

//  Multi-word sequential adder/subtractor that feeds the 32-bit carry-skip adder (csa32) and consumes its output.

---
 rtl/mw_adder_seq_pkg.sv | 17 +
 rtl/mw_adder_seq_csa32.sv | 36 +++
 rtl/mw_adder_seq.sv | 118 +++++++++++
 tb/tb_mw_adder_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mw_adder_seq_pkg.sv
// Shared definitions for the multi-word sequential adder: slice width, FSM
// state encoding and word-index sizing.
package mw_adder_seq_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mw_adder_seq_csa32.sv
// 32-bit carry-skip adder: eight 4-bit ripple blocks, each bypassed when all
// of its bits propagate.
module csa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic c;
    logic c_blk;
    logic p_blk;
    logic p;
    sum   = '0;
    c     = cin;
    c_blk = cin;
    p_blk = 1'b1;
    p     = 1'b0;
    for (int unsigned blk = 0; blk < 8; blk++) begin
      c_blk = c;
      p_blk = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        p                  = a[5'(blk * 4 + i)] ^ b[5'(blk * 4 + i)];
        sum[5'(blk * 4 + i)] = p ^ c;
        c                  = (a[5'(blk * 4 + i)] & b[5'(blk * 4 + i)]) | (p & c);
        p_blk              = p_blk & p;
      end
      // A fully propagating block passes its incoming carry straight through.
      if (p_blk) c = c_blk;
    end
    cout = c;
  end

endmodule

// File: rtl/mw_adder_seq.sv
// Multi-word adder/subtractor: runs WORDS 32-bit slices through one csa32,
// least-significant word first, chaining the carry through a register.
module mw_adder_seq
  import mw_adder_seq_pkg::*;
#(
  parameter int unsigned WORDS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] op_a,
  input  logic [WORDS*WORD_W-1:0] op_b,
  input  logic                    sub,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] result,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned     W        = WORDS * WORD_W;
  localparam int unsigned     IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e                         state_q, state_d;
  logic [WORDS-1:0][WORD_W-1:0]   a_q, a_d;
  logic [WORDS-1:0][WORD_W-1:0]   b_q, b_d;
  logic [WORDS-1:0][WORD_W-1:0]   res_q, res_d;
  logic                           carry_q, carry_d;
  logic                           cout_q, cout_d;
  logic                           ovf_q, ovf_d;
  logic [IDX_W-1:0]               idx_q, idx_d;

  logic [WORD_W-1:0]              a_w, b_w, sum_w;
  logic                           carry_w;

  assign a_w = a_q[idx_q];
  assign b_w = b_q[idx_q];

  csa32 u_csa32 (
    .a   (a_w),
    .b   (b_w),
    .cin (carry_q),
    .sum (sum_w),
    .cout(carry_w)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {W{sub}};
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = sum_w;
        carry_d      = carry_w;
        if (idx_q == LAST_IDX) begin
          cout_d  = carry_w;
          ovf_d   = (a_w[WORD_W-1] == b_w[WORD_W-1]) && (sum_w[WORD_W-1] != a_w[WORD_W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = ~rst;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mw_adder_seq.sv
// Directed bench for mw_adder_seq with WORDS=2: expected results are queued at
// accept time and compared when the adder presents them.
module tb_mw_adder_seq;

  localparam int unsigned WORDS = 2;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        cout;
  logic        ovf;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mw_adder_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .sub      (sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic c);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] t;
    bb   = s ? ~b : b;
    t    = {1'b0, a} + {1'b0, bb} + {64'd0, (s ? 1'b1 : c)};
    e.res = t[63:0];
    e.co  = t[64];
    e.ov  = (a[63] == bb[63]) && (t[63] != a[63]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] r, input logic co, input logic ov);
    exp_t e;
    e.res = r;
    e.co  = co;
    e.ov  = ov;
    return e;
  endfunction

  // Drives one request and returns #1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic c, input exp_t e, input bit push);
    int n;
    op_a     = a;
    op_b     = b;
    sub      = s;
    cin      = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk("accept_ready", {64'd0, in_ready}, 65'd1);
    step();
    in_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  // Waits for out_valid, optionally checks latency, compares and consumes.
  task automatic recv(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {64'd0, out_valid}, 65'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 65'(n), 65'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 65'd0, 65'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, {1'b0, result}, {1'b0, e.res});
      chk({tag, "_cout"}, {64'd0, cout}, {64'd0, e.co});
      chk({tag, "_ovf"}, {64'd0, ovf}, {64'd0, e.ov});
    end
    step();
    out_ready = 1'b0;
    chk({tag, "_ovalid_drop"}, {64'd0, out_valid}, 65'd0);
    chk({tag, "_iready_rise"}, {64'd0, in_ready}, 65'd1);
  endtask

  initial begin
    exp_t e;
    logic [63:0] ra, rb;
    logic        rs, rc;

    // Reset state
    step();
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_result", {1'b0, result}, 65'd0);
    chk("rst_cout", {64'd0, cout}, 65'd0);
    chk("rst_ovf", {64'd0, ovf}, 65'd0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_in_ready_after", {64'd0, in_ready}, 65'd1);

    // Carry across the word boundary, with latency check
    send(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, mk(64'h00000001_00000000, 1'b0, 1'b0), 1);
    recv("t1", 2);

    // Full wrap-around with carry-in
    send(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b1, mk(64'h00000000_00000001, 1'b1, 1'b0), 1);
    recv("t2", 2);

    // Subtraction, cin ignored
    send(64'd5, 64'd7, 1'b1, 1'b1, mk(64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0), 1);
    recv("t3a", 2);
    send(64'd7, 64'd5, 1'b1, 1'b0, mk(64'd2, 1'b1, 1'b0), 1);
    recv("t3b", 2);

    // Signed overflow
    send(64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, mk(64'h80000000_00000000, 1'b0, 1'b1), 1);
    recv("t4", 2);

    // Backpressure: hold in DONE, stray in_valid pulses must be ignored
    send(64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 1'b0, 1'b0,
         mk(64'h0000_0004_0000_0000, 1'b0, 1'b0), 1);
    step();
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      op_a     = 64'hDEAD_BEEF_0000_0000;
      op_b     = 64'h1111_1111_1111_1111;
      in_valid = i[0];
      chk("bp_out_valid", {64'd0, out_valid}, 65'd1);
      chk("bp_in_ready", {64'd0, in_ready}, 65'd0);
      chk("bp_result", {1'b0, result}, {1'b0, sb[0].res});
      chk("bp_cout", {64'd0, cout}, {64'd0, sb[0].co});
      chk("bp_ovf", {64'd0, ovf}, {64'd0, sb[0].ov});
      step();
    end
    in_valid = 1'b0;
    recv("t5", 0);
    send(64'd100, 64'd23, 1'b0, 1'b0, mk(64'd123, 1'b0, 1'b0), 1);
    recv("t5n", 2);

    // Reset one cycle after accept aborts the operation
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, mk('0, 1'b0, 1'b0), 0);
    rst = 1'b1;
    step();
    chk("t6_result", {1'b0, result}, 65'd0);
    chk("t6_cout", {64'd0, cout}, 65'd0);
    chk("t6_ovf", {64'd0, ovf}, 65'd0);
    chk("t6_out_valid", {64'd0, out_valid}, 65'd0);
    chk("t6_in_ready_rst", {64'd0, in_ready}, 65'd0);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", {64'd0, in_ready}, 65'd1);
    step();
    chk("t6_still_idle", {64'd0, out_valid}, 65'd0);
    send(64'h12345678_9ABCDEF0, 64'd1, 1'b0, 1'b0, mk(64'h12345678_9ABCDEF1, 1'b0, 1'b0), 1);
    recv("t6n", 2);

    // A few pseudo-random operations against the arithmetic model
    for (int unsigned k = 0; k < 6; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs, rc);
      send(ra, rb, rs, rc, e, 1);
      recv("rnd", 2);
    end

    chk("sb_drained", 65'(sb.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
